// File: rtl/rd_responder.sv
// rd_responder: target-side read responder.
// Accepts a read request (start address + burst length), fetches each word
// from a fixed-latency synchronous memory one at a time, and returns the words
// on a valid/ready response channel with the final word flagged by rsp_last.
// Every output is driven straight from a register.

module rd_responder #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int LW      = 4,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic [AW-1:0] rd_addr,
    input  logic [LW-1:0] rd_len,
    output logic          rd_ack,
    output logic          busy,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    input  logic          rsp_ready
);

    // Latency counter needs at least one bit even when MEM_LAT is 1.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [CW-1:0] lat_q, lat_d;

    logic          rd_ack_d;
    logic          busy_d;
    logic          mem_en_d;
    logic [AW-1:0] mem_addr_d;
    logic          rsp_valid_d;
    logic [DW-1:0] rsp_data_d;
    logic          rsp_last_d;

    // State, counters and registered outputs; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            lat_q     <= '0;
            rd_ack    <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            lat_q     <= lat_d;
            rd_ack    <= rd_ack_d;
            busy      <= busy_d;
            mem_en    <= mem_en_d;
            mem_addr  <= mem_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_last  <= rsp_last_d;
        end
    end

    // Next state plus next output values; outputs are set one cycle early so they land registered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        lat_d       = lat_q;
        rd_ack_d    = 1'b0;
        busy_d      = busy;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_last_d  = rsp_last;

        case (state_q)
            IDLE: begin
                busy_d      = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
                if (rd) begin
                    addr_d     = rd_addr;
                    remain_d   = rd_len;
                    rd_ack_d   = 1'b1;
                    busy_d     = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = rd_addr;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                lat_d   = CW'(MEM_LAT - 1);
                state_d = WAIT;
            end

            WAIT: begin
                if (lat_q == '0) begin
                    rsp_data_d  = mem_rdata;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (remain_q == '0);
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - CW'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (remain_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        remain_d   = remain_q - LW'(1);
                        addr_d     = addr_q + AW'(1);
                        mem_en_d   = 1'b1;
                        mem_addr_d = addr_q + AW'(1);
                        state_d    = FETCH;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rd_responder.sv
// tb_rd_responder: two responders (memory latency 2 and 1) driven by random
// and directed bursts; expected cycle behaviour is derived from the burst
// timing rules (fetch cycle, latency, handshake cycle) rather than a state machine.

module tb_rd_responder;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n     [2];
    logic          rd        [2];
    logic [AW-1:0] rd_addr   [2];
    logic [LW-1:0] rd_len    [2];
    logic          rsp_ready [2];
    logic          rd_ack    [2];
    logic          busy      [2];
    logic          mem_en    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_rdata [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_data  [2];
    logic          rsp_last  [2];
    logic [31:0]   noise = 32'h1234_5678;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Bus carries random junk whenever no read result is due.
    always @(posedge clk) noise <= $urandom;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a} ^ 16'hA5A5;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : inst
            localparam int LAT = (g == 0) ? 2 : 1;
            logic [DW-1:0] pipe_d [LAT];
            logic          pipe_v [LAT];

            rd_responder #(.AW(AW), .DW(DW), .LW(LW), .MEM_LAT(LAT)) dut (
                .clk       (clk),
                .rst_n     (rst_n[g]),
                .rd        (rd[g]),
                .rd_addr   (rd_addr[g]),
                .rd_len    (rd_len[g]),
                .rd_ack    (rd_ack[g]),
                .busy      (busy[g]),
                .mem_en    (mem_en[g]),
                .mem_addr  (mem_addr[g]),
                .mem_rdata (mem_rdata[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_data  (rsp_data[g]),
                .rsp_last  (rsp_last[g]),
                .rsp_ready (rsp_ready[g])
            );

            always @(posedge clk) begin
                pipe_d[0] <= memval(mem_addr[g]);
                pipe_v[0] <= mem_en[g];
                for (int i = 1; i < LAT; i++) begin
                    pipe_d[i] <= pipe_d[i-1];
                    pipe_v[i] <= pipe_v[i-1];
                end
            end

            assign mem_rdata[g] = (pipe_v[LAT-1] === 1'b1) ? pipe_d[LAT-1] : noise[DW-1:0];
        end
    endgenerate

    // Runs one burst from the current (IDLE) negedge and checks every cycle until the idle cycle after it.
    task automatic run_burst(input int u, input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input int stall_pct, input int first_stall, input bit hold,
                             input logic [AW-1:0] na, input logic [LW-1:0] nn, input string tag);
        int lat = lat_of(u);
        int k = 0;
        int fetch_cyc = 1;
        int stalled = 0;
        int t = 0;
        bit done = 1'b0;
        bit exp_en, exp_valid, rdy;
        logic [AW-1:0] wa;
        rd[u] = 1'b1;
        rd_addr[u] = a;
        rd_len[u] = n;
        while (!done) begin
            @(negedge clk);
            t++;
            if (t > 400) begin
                total++; bad++;
                $display("[TB] FAIL %s timeout got=%0d cycles want<=400", tag, t);
                rd[u] = 1'b0;
                return;
            end
            exp_en = (t == fetch_cyc);
            exp_valid = (t >= fetch_cyc + lat + 1);
            wa = a + AW'(k);
            total++;
            if (rd_ack[u] !== (t == 1)) begin
                bad++; $display("[TB] FAIL %s rd_ack t=%0d got=%0b want=%0b", tag, t, rd_ack[u], (t == 1));
            end
            total++;
            if (busy[u] !== 1'b1) begin
                bad++; $display("[TB] FAIL %s busy t=%0d got=%0b want=1", tag, t, busy[u]);
            end
            total++;
            if (mem_en[u] !== exp_en) begin
                bad++; $display("[TB] FAIL %s mem_en t=%0d got=%0b want=%0b", tag, t, mem_en[u], exp_en);
            end
            if (exp_en) begin
                total++;
                if (mem_addr[u] !== wa) begin
                    bad++; $display("[TB] FAIL %s mem_addr t=%0d got=%h want=%h", tag, t, mem_addr[u], wa);
                end
            end
            total++;
            if (rsp_valid[u] !== exp_valid) begin
                bad++; $display("[TB] FAIL %s rsp_valid t=%0d got=%0b want=%0b", tag, t, rsp_valid[u], exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (rsp_data[u] !== memval(wa)) begin
                    bad++; $display("[TB] FAIL %s rsp_data t=%0d got=%h want=%h", tag, t, rsp_data[u], memval(wa));
                end
                total++;
                if (rsp_last[u] !== (k == int'(n))) begin
                    bad++; $display("[TB] FAIL %s rsp_last t=%0d got=%0b want=%0b", tag, t, rsp_last[u], (k == int'(n)));
                end
            end
            if (exp_valid && stalled < first_stall) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            rsp_ready[u] = rdy;
            if (exp_valid && rdy) begin
                if (k == int'(n)) done = 1'b1;
                else begin
                    k++;
                    fetch_cyc = t + 1;
                end
            end
            if (t == 1) begin
                if (hold) begin
                    rd_addr[u] = na;
                    rd_len[u] = nn;
                end else begin
                    rd[u] = 1'b0;
                end
            end
        end
        @(negedge clk);
        total++;
        if (busy[u] !== 1'b0 || rsp_valid[u] !== 1'b0 || rsp_last[u] !== 1'b0 ||
            mem_en[u] !== 1'b0 || rd_ack[u] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s idle_after got=busy%0b/valid%0b/last%0b/en%0b/ack%0b want=all 0",
                     tag, busy[u], rsp_valid[u], rsp_last[u], mem_en[u], rd_ack[u]);
        end
        rsp_ready[u] = 1'($urandom_range(1));
    endtask

    // Holds both responders in reset, checks every output is cleared, then releases.
    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; rd[u] = 1'b0; rd_addr[u] = '0; rd_len[u] = '0; rsp_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (rd_ack[u] !== 1'b0 || busy[u] !== 1'b0 || mem_en[u] !== 1'b0 || mem_addr[u] !== '0 ||
                rsp_valid[u] !== 1'b0 || rsp_data[u] !== '0 || rsp_last[u] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset u%0d got=ack%0b busy%0b en%0b addr%h valid%0b data%h last%0b want=all 0",
                         u, rd_ack[u], busy[u], mem_en[u], mem_addr[u], rsp_valid[u], rsp_data[u], rsp_last[u]);
            end
            rst_n[u] = 1'b1;
        end
        @(negedge clk);
    endtask

    // Single-word read at 0x10: the shortest burst.
    task automatic test_single(input int u);
        run_burst(u, 8'h10, 4'd0, 0, 0, 1'b0, 8'h00, 4'd0, $sformatf("single_u%0d", u));
    endtask

    // Four-word burst crossing the top of the address space.
    task automatic test_burst_wrap(input int u);
        run_burst(u, 8'hFE, 4'd3, 0, 0, 1'b0, 8'h00, 4'd0, $sformatf("wrap_u%0d", u));
    endtask

    // Initiator stalls the first response for five cycles.
    task automatic test_backpressure(input int u);
        run_burst(u, 8'h55, 4'd1, 0, 5, 1'b0, 8'h00, 4'd0, $sformatf("bp_u%0d", u));
    endtask

    // rd stays high through a burst; the follow-up request at 0x40 is taken in the first idle cycle.
    task automatic test_back_to_back(input int u);
        run_burst(u, 8'h30, 4'd2, 0, 0, 1'b1, 8'h40, 4'd0, $sformatf("b2b_first_u%0d", u));
        run_burst(u, 8'h40, 4'd0, 0, 0, 1'b0, 8'h00, 4'd0, $sformatf("b2b_second_u%0d", u));
    endtask

    // Reset while waiting on memory: outputs clear at once and nothing is presented afterwards.
    task automatic test_reset_mid_burst(input int u);
        rd[u] = 1'b1; rd_addr[u] = 8'h20; rd_len[u] = 4'd2; rsp_ready[u] = 1'b1;
        @(negedge clk);
        rd[u] = 1'b0;
        @(negedge clk);
        rst_n[u] = 1'b0;
        #1;
        total++;
        if (rd_ack[u] !== 1'b0 || busy[u] !== 1'b0 || mem_en[u] !== 1'b0 || mem_addr[u] !== '0 ||
            rsp_valid[u] !== 1'b0 || rsp_data[u] !== '0 || rsp_last[u] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_u%0d got=ack%0b busy%0b en%0b addr%h valid%0b data%h last%0b want=all 0",
                     u, rd_ack[u], busy[u], mem_en[u], mem_addr[u], rsp_valid[u], rsp_data[u], rsp_last[u]);
        end
        @(negedge clk);
        rst_n[u] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid[u] !== 1'b0 || mem_en[u] !== 1'b0 || busy[u] !== 1'b0 || rsp_last[u] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL postreset_u%0d cyc=%0d got=valid%0b en%0b busy%0b last%0b want=all 0",
                         u, i, rsp_valid[u], mem_en[u], busy[u], rsp_last[u]);
            end
        end
        run_burst(u, 8'h21, 4'd1, 0, 0, 1'b0, 8'h00, 4'd0, $sformatf("recover_u%0d", u));
    endtask

    // Random addresses, lengths and ready patterns.
    task automatic test_random(input int u);
        for (int i = 0; i < 6; i++) begin
            run_burst(u, AW'($urandom), LW'($urandom), 40, 0, 1'b0, 8'h00, 4'd0,
                      $sformatf("rand_u%0d_%0d", u, i));
        end
    endtask

    initial begin
        test_reset();
        test_single(0);
        test_burst_wrap(0);
        test_backpressure(0);
        test_back_to_back(0);
        test_reset_mid_burst(0);
        test_random(0);
        test_single(1);
        test_burst_wrap(1);
        test_backpressure(1);
        test_back_to_back(1);
        test_reset_mid_burst(1);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
